// File: rtl/friscv_apb_initiator.sv
// friscv_apb_initiator: single-outstanding request/completion bridge onto the APB-style peripheral bus,
// with a watchdog that ends transfers the slave never acknowledges.
module friscv_apb_initiator #(
   parameter int ADDRW   = 16,
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
)(
   input  logic              aclk,
   input  logic              srst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDRW-1:0]  req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [XLEN/8-1:0] req_strb,
   output logic              cpl_valid,
   input  logic              cpl_ready,
   output logic [XLEN-1:0]   cpl_rdata,
   output logic              cpl_err,
   output logic              mst_en,
   output logic              mst_wr,
   output logic [ADDRW-1:0]  mst_addr,
   output logic [XLEN-1:0]   mst_wdata,
   output logic [XLEN/8-1:0] mst_strb,
   input  logic [XLEN-1:0]   mst_rdata,
   input  logic              mst_ready
);
   localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic w_accept, w_done, w_tmo, w_consume;
   assign w_accept  = r_state == IDLE && req_valid && req_ready;
   assign w_done    = r_state == ACCESS && mst_ready;
   // The final count edge times out only if the slave is silent; a ready in that cycle wins
   assign w_tmo     = TIMEOUT != 0 && r_state == ACCESS && !mst_ready && r_cnt == LAST;
   assign w_consume = r_state == RESP && cpl_ready;
   always_comb begin
      w_next = r_state;
      if (w_accept) w_next = ACCESS;
      else if (w_done || w_tmo) w_next = RESP;
      else if (w_consume) w_next = IDLE;
   end
   always_ff @(posedge aclk) begin
      if (srst) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_ff @(posedge aclk) begin
      if (srst) begin
         req_ready <= 1'b0;
         cpl_valid <= 1'b0;
         cpl_rdata <= '0;
         cpl_err   <= 1'b0;
         mst_en    <= 1'b0;
         mst_wr    <= 1'b0;
         mst_addr  <= '0;
         mst_wdata <= '0;
         mst_strb  <= '0;
         r_cnt     <= '0;
      end else begin
         req_ready <= w_next == IDLE;
         r_cnt     <= (r_state == ACCESS && !mst_ready) ? r_cnt + 1'b1 : '0;
         if (w_accept) begin
            mst_en    <= 1'b1;
            mst_wr    <= req_wr;
            mst_addr  <= req_addr;
            mst_wdata <= req_wdata;
            mst_strb  <= req_strb;
         end
         // en drops on the same edge ready is seen so the slave never re-arms for a duplicate
         if (w_done || w_tmo) begin
            mst_en    <= 1'b0;
            cpl_valid <= 1'b1;
            cpl_err   <= w_tmo;
            cpl_rdata <= (w_done && !mst_wr) ? mst_rdata : '0;
         end
         if (w_consume) cpl_valid <= 1'b0;
      end
   end
endmodule
